// File: rtl/byte_dispatch_deframer.sv
// Byte-stream deframer: assembles MSB-first dispatch instructions (NOP/RUN/SPK/CLR)
// from a host byte link into one MSB-aligned src word per instruction.
module byte_dispatch_deframer #(
  parameter int OPC_WIDTH = 2,
  parameter int RUN_WIDTH = 16,
  parameter int SPK_WIDTH = 12,
  parameter int SRC_WIDTH = 18
) (
  input  logic                 clk,
  input  logic                 arst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [7:0]           in_byte,
  output logic                 src_valid,
  input  logic                 src_ready,
  output logic [SRC_WIDTH-1:0] src,
  output logic                 busy
);

  localparam int NB_RUN = (OPC_WIDTH + RUN_WIDTH + 7) / 8;
  localparam int NB_SPK = (OPC_WIDTH + SPK_WIDTH + 7) / 8;
  localparam int NB_MAX = (NB_RUN > NB_SPK) ? NB_RUN : NB_SPK;
  localparam int BUF_W  = 8 * NB_MAX;
  localparam int IDX_W  = (NB_MAX > 1) ? $clog2(NB_MAX) : 1;

  localparam logic [OPC_WIDTH-1:0] OPC_NOP = OPC_WIDTH'(0);
  localparam logic [OPC_WIDTH-1:0] OPC_RUN = OPC_WIDTH'(1);
  localparam logic [OPC_WIDTH-1:0] OPC_SPK = OPC_WIDTH'(2);

  // Handshake: a byte transfers on in_valid && in_ready, a word on src_valid && src_ready;
  // valid never depends on ready, and in_ready frees up in the same cycle src is popped.

  logic [IDX_W-1:0]     idx, last_idx, last_idx_q;
  logic [OPC_WIDTH-1:0] opc, opc_q;
  logic [BUF_W-1:0]     asm_buf, buf_next;
  logic                 first, last, accept, fire;

  assign in_ready = !arst && (!src_valid || src_ready);
  assign accept   = in_valid && in_ready;
  assign busy     = (idx != '0);

  always_comb begin
    first    = (idx == '0);
    opc      = first ? in_byte[7 -: OPC_WIDTH] : opc_q;
    last_idx = last_idx_q;
    if (first) begin
      case (opc)
        OPC_RUN: last_idx = IDX_W'(NB_RUN - 1);
        OPC_SPK: last_idx = IDX_W'(NB_SPK - 1);
        default: last_idx = '0;
      endcase
    end
    last = (idx == last_idx);
    fire = accept && last && (opc != OPC_NOP);
    // A new instruction starts from an all-zero buffer so short words have zero tails.
    buf_next = first ? '0 : asm_buf;
    for (int k = 0; k < NB_MAX; k++) begin
      if (idx == IDX_W'(k)) buf_next[8*(NB_MAX-k)-1 -: 8] = in_byte;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      idx        <= '0;
      last_idx_q <= '0;
      opc_q      <= '0;
      asm_buf    <= '0;
      src_valid  <= 1'b0;
      src        <= '0;
    end else begin
      if (accept) begin
        asm_buf <= buf_next;
        if (first) begin
          opc_q      <= opc;
          last_idx_q <= last_idx;
        end
        idx <= last ? '0 : idx + IDX_W'(1);
      end
      // src is its own register so a stalled word survives further assembly.
      if (fire) begin
        src_valid <= 1'b1;
        src       <= buf_next[BUF_W-1 -: SRC_WIDTH];
      end else if (src_ready) begin
        src_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/byte_dispatch_deframer.md
Name: byte_dispatch_deframer

Overview:
- Upstream neighbour of the network source stage. Accepts a byte stream from the host link (UART/FIFO) with a valid/ready handshake.
- Assembles variable-length, MSB-first dispatch instructions and presents each as one MSB-aligned `src` word on the valid/ready interface the source stage consumes.
- Opcode determines instruction length. NOP bytes are consumed and never forwarded.

Parameters:
- OPC_WIDTH, 2, opcode field width; opcodes NOP=0, RUN=1, SPK=2, CLR=3.
- RUN_WIDTH, 16, RUN payload width.
- SPK_WIDTH, 12, SPK payload width (input index + charge).
- SRC_WIDTH, 18, output word width; must equal OPC_WIDTH + max(RUN_WIDTH, SPK_WIDTH).
- Derived localparams (not overridable):
  - NB_RUN = ceil((OPC_WIDTH+RUN_WIDTH)/8).
  - NB_SPK = ceil((OPC_WIDTH+SPK_WIDTH)/8).
  - NB_MAX = max(NB_RUN, NB_SPK), with 8*NB_MAX >= SRC_WIDTH.

Ports:
- clk  input  1  sole clock, rising edge.
- arst  input  1  asynchronous, active-high reset.
- in_valid  input  1  byte valid.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- in_byte  input  8  stream byte, MSB-first.
- src_valid  output  1  assembled instruction valid.
- src_ready  input  1  downstream accepts when src_valid && src_ready.
- src  output  SRC_WIDTH  instruction; opcode in bits [SRC_WIDTH-1 -: OPC_WIDTH].
- busy  output  1  partial instruction in progress.

Behaviour:
- Interface: one clock, clk; asynchronous active-high reset, arst.
- Reset values: src_valid=0, src=0, busy=0, byte count=0, assembly buffer=0. in_ready=1 once arst deasserts.
- State is a byte index `idx` (0..NB_MAX-1), a target length `nb`, and an 8*NB_MAX-bit buffer `buf`.
- First byte (idx==0):
  - Opcode = in_byte[7 -: OPC_WIDTH].
  - nb per opcode: NOP=1, CLR=1, RUN=NB_RUN, SPK=NB_SPK.
  - buf is cleared except the byte written.
- Byte k of an instruction is written to buf[8*(NB_MAX-k)-1 -: 8]. Unwritten low bytes stay zero.
- On accepting the last byte (idx==nb-1):
  - Opcode != NOP: next cycle src_valid=1 and src = final buf[8*NB_MAX-1 -: SRC_WIDTH], including the byte just accepted. Latency is exactly 1 cycle from last-byte acceptance.
  - Opcode == NOP: nothing is forwarded and idx returns to 0.
- busy=1 whenever idx != 0.
- in_ready = !src_valid || src_ready. Consequences:
  - A completed word may be consumed and the next byte accepted in the same cycle.
  - Sustained throughput is 1 byte/cycle, including back-to-back 1-byte CLRs.
- src and src_valid are held stable while src_valid && !src_ready. No byte is accepted during the stall; buf must not corrupt the held src (src is a separate register).
- Simultaneous pop of held word and completion of a new instruction: src_valid stays 1 and src updates to the new word next cycle.
- Bytes after a partial instruction are always payload. There is no resync mechanism; framing is the host's responsibility.
- arst mid-instruction or while src_valid: partial and held words are discarded immediately, all outputs return to reset values asynchronously.
- in_valid low between bytes of one instruction is legal and stalls assembly indefinitely.

Test Plan:
- Reset, then bytes 0x40,0x01,0x40 (RUN 5) -> one cycle after third byte: src_valid=1, src=18'h10005; busy=1 after byte 1 until last byte.
- Bytes 0x8F,0xF8 (SPK idx 3, charge -2) -> src=18'h23FE0, latency 1 cycle.
- Bytes 0x00,0x00,0xC0 with src_ready=1 -> NOPs dropped; exactly one output src=18'h30000 (CLR), one cycle after the 0xC0 byte.
- Five consecutive 0xC0 bytes, in_valid and src_ready held high -> in_ready stays 1; five outputs on five consecutive cycles.
- Complete RUN with src_ready=0 for 4 cycles -> in_ready=0 and src held stable; on src_ready=1, next byte accepted the same cycle.
- Assert arst after bytes 0x40,0x01 -> busy=0, src_valid=0; then 0xC0 -> src=18'h30000 with no leftover RUN bytes.
